// File: rtl/img_cmd_sequencer.sv
// Sequences ImgController capture/readout commands on the img clock domain and reports
// completion (or per-phase timeout) with the number of readout words seen.
module img_cmd_sequencer #(
    parameter int ClkFreq          = 108_000_000,
    parameter int WordCount        = 0,
    parameter int ThumbWordCount   = 0,
    parameter int PaddingWordCount = 0,
    parameter int TimeoutUs        = 10_000
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_capture,
    input  logic        req_readout,
    input  logic        req_ramBlock,
    input  logic        req_skipCount,
    input  logic        req_thumb,
    output logic        cmd_capture,
    output logic        cmd_readout,
    output logic        cmd_ramBlock,
    output logic        cmd_skipCount,
    output logic        cmd_thumb,
    input  logic        status_captureDone,
    input  logic        readout_ready,
    input  logic        readout_trigger,
    output logic        busy,
    output logic        done,
    output logic        done_err,
    output logic [23:0] done_wordCount
);

    localparam int TimeoutCycles = ClkFreq / 1_000_000 * TimeoutUs;
    localparam int TimerW = $clog2(TimeoutCycles + 2);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles);
    localparam logic [23:0] FullWords  = 24'(WordCount + PaddingWordCount);
    localparam logic [23:0] ThumbWords = 24'(ThumbWordCount + PaddingWordCount);
    localparam logic [23:0] CntMax = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP_ISSUE,
        S_CAP_WAIT,
        S_RD_ISSUE,
        S_RD_COUNT,
        S_DONE
    } state_t;

    state_t            state;
    logic              cap_ref;
    logic              rd_pend;
    logic [TimerW-1:0] timer;
    logic [23:0]       word_cnt;
    logic [23:0]       word_cnt_inc;
    logic [23:0]       expected;
    logic              word_hs;

    assign word_hs      = readout_ready && readout_trigger;
    assign word_cnt_inc = (word_cnt == CntMax) ? word_cnt : word_cnt + 24'd1;
    assign expected     = cmd_thumb ? ThumbWords : FullWords;

    // Command toggles flip on the edge that enters an *_ISSUE state, so the
    // ImgController sees the command one cycle after the accepting/finishing cycle.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            cmd_capture    <= 1'b0;
            cmd_readout    <= 1'b0;
            cmd_ramBlock   <= 1'b0;
            cmd_skipCount  <= 1'b0;
            cmd_thumb      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            done_err       <= 1'b0;
            done_wordCount <= '0;
            cap_ref        <= 1'b0;
            rd_pend        <= 1'b0;
            timer          <= '0;
            word_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cmd_ramBlock  <= req_ramBlock;
                        cmd_skipCount <= req_skipCount;
                        cmd_thumb     <= req_thumb;
                        rd_pend       <= req_readout;
                        req_ready     <= 1'b0;
                        busy          <= 1'b1;
                        if (req_capture) begin
                            cmd_capture <= ~cmd_capture;
                            state       <= S_CAP_ISSUE;
                        end else if (req_readout) begin
                            cmd_readout <= ~cmd_readout;
                            state       <= S_RD_ISSUE;
                        end else begin
                            done           <= 1'b1;
                            done_err       <= 1'b0;
                            done_wordCount <= '0;
                            state          <= S_DONE;
                        end
                    end
                end
                S_CAP_ISSUE: begin
                    cap_ref <= status_captureDone;
                    timer   <= '0;
                    state   <= S_CAP_WAIT;
                end
                S_CAP_WAIT: begin
                    if (status_captureDone != cap_ref) begin
                        if (rd_pend) begin
                            cmd_readout <= ~cmd_readout;
                            state       <= S_RD_ISSUE;
                        end else begin
                            done           <= 1'b1;
                            done_err       <= 1'b0;
                            done_wordCount <= '0;
                            state          <= S_DONE;
                        end
                    end else if (timer == TimerMax) begin
                        done           <= 1'b1;
                        done_err       <= 1'b1;
                        done_wordCount <= '0;
                        state          <= S_DONE;
                    end else begin
                        timer <= timer + TimerW'(1);
                    end
                end
                S_RD_ISSUE: begin
                    word_cnt <= '0;
                    timer    <= '0;
                    state    <= S_RD_COUNT;
                end
                S_RD_COUNT: begin
                    // Expected==0 finishes immediately; otherwise the word that reaches it counts.
                    if (word_cnt >= expected) begin
                        done           <= 1'b1;
                        done_err       <= 1'b0;
                        done_wordCount <= word_cnt;
                        state          <= S_DONE;
                    end else if (word_hs) begin
                        word_cnt <= word_cnt_inc;
                        timer    <= '0;
                        if (word_cnt_inc >= expected) begin
                            done           <= 1'b1;
                            done_err       <= 1'b0;
                            done_wordCount <= word_cnt_inc;
                            state          <= S_DONE;
                        end
                    end else if (timer == TimerMax) begin
                        done           <= 1'b1;
                        done_err       <= (word_cnt != expected);
                        done_wordCount <= word_cnt;
                        state          <= S_DONE;
                    end else begin
                        timer <= timer + TimerW'(1);
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_cmd_sequencer.sv
// Bench for img_cmd_sequencer: emulates ImgController handshakes and compares done/err/count
// and command-toggle timing against a request-level reference model.
module tb_img_cmd_sequencer;

    localparam int CLK_FREQ = 1_000_000;
    localparam int WORDS    = 40;
    localparam int THUMB    = 12;
    localparam int PAD      = 4;
    localparam int TO_US    = 200;
    localparam int T        = CLK_FREQ / 1_000_000 * TO_US;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req_valid = 1'b0, req_capture = 1'b0, req_readout = 1'b0;
    logic        req_ramBlock = 1'b0, req_skipCount = 1'b0, req_thumb = 1'b0;
    logic        status_captureDone = 1'b0, readout_ready = 1'b0, readout_trigger = 1'b0;
    logic        req_ready, cmd_capture, cmd_readout, cmd_ramBlock, cmd_skipCount, cmd_thumb;
    logic        busy, done, done_err;
    logic [23:0] done_wordCount;

    img_cmd_sequencer #(
        .ClkFreq(CLK_FREQ), .WordCount(WORDS), .ThumbWordCount(THUMB),
        .PaddingWordCount(PAD), .TimeoutUs(TO_US)
    ) dut (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready),
        .req_capture(req_capture), .req_readout(req_readout), .req_ramBlock(req_ramBlock),
        .req_skipCount(req_skipCount), .req_thumb(req_thumb), .cmd_capture(cmd_capture),
        .cmd_readout(cmd_readout), .cmd_ramBlock(cmd_ramBlock), .cmd_skipCount(cmd_skipCount),
        .cmd_thumb(cmd_thumb), .status_captureDone(status_captureDone),
        .readout_ready(readout_ready), .readout_trigger(readout_trigger), .busy(busy),
        .done(done), .done_err(done_err), .done_wordCount(done_wordCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor on the falling edge
    int   cap_tog = 0, rd_tog = 0, done_cnt = 0, arg_chg = 0;
    int   cap_tog_cyc = 0, rd_tog_cyc = 0, done_cyc = 0;
    logic last_err = 1'b0;
    logic [23:0] last_wc = '0;
    logic p_cap = 1'b0, p_rd = 1'b0, p_busy = 1'b0;
    logic [2:0] p_args = '0;
    always @(negedge clk) begin
        if (cmd_capture !== p_cap) begin cap_tog++; cap_tog_cyc = cyc; end
        if (cmd_readout !== p_rd)  begin rd_tog++;  rd_tog_cyc  = cyc; end
        if (done === 1'b1) begin
            done_cnt++; done_cyc = cyc; last_err = done_err; last_wc = done_wordCount;
        end
        if (busy === 1'b1 && p_busy === 1'b1 && {cmd_ramBlock, cmd_skipCount, cmd_thumb} !== p_args)
            arg_chg++;
        p_cap = cmd_capture; p_rd = cmd_readout; p_busy = busy;
        p_args = {cmd_ramBlock, cmd_skipCount, cmd_thumb};
    end

    int total = 0, bad = 0;
    int last_drv = 0, last_acc = 0, last_stat = 0, last_word = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin tick(); n++; end
        check({tag, "_done_seen"}, done_cnt != d0, 1);
    endtask

    task automatic wait_rd(input int r0, input string tag);
        int n = 0;
        while (rd_tog == r0 && n < 3000) begin tick(); n++; end
        check({tag, "_rd_toggle_seen"}, rd_tog != r0, 1);
    endtask

    // Request-level reference: what done_err / done_wordCount / readout toggles must be.
    function automatic void model(input bit cap, input bit rd, input bit thumb, input bit cap_ok,
                                  input int supply, input int stall_at, input int stall_len,
                                  output bit err, output int wc, output int rdt);
        int need, got;
        need = thumb ? THUMB + PAD : WORDS + PAD;
        if (cap && !cap_ok) begin err = 1; wc = 0; rdt = 0; end
        else if (!rd)       begin err = 0; wc = 0; rdt = 0; end
        else begin
            rdt = 1;
            // a silent gap longer than the timeout ends the readout early
            got = (stall_len > T && stall_at < supply) ? stall_at : supply;
            if (got >= need) begin wc = need; err = 0; end
            else             begin wc = got;  err = 1; end
        end
    endfunction

    task automatic supply_words(input int supply, input int stall_at, input int stall_len,
                                input bit gaps);
        int sent = 0;
        int v;
        while (sent < supply) begin
            if (sent == stall_at && stall_len > 0) repeat (stall_len) tick();
            if (gaps) repeat ($urandom_range(0, 2)) begin
                v = $urandom_range(0, 2);
                readout_ready = (v == 1); readout_trigger = (v == 2);
                tick();
            end
            readout_ready = 1'b1; readout_trigger = 1'b1; last_word = cyc;
            tick();
            sent++;
            readout_ready = 1'b0; readout_trigger = 1'b0;
        end
    endtask

    task automatic run_req(input bit cap, input bit rd, input bit ram, input bit skip,
                           input bit thumb, input int cap_delay, input int supply,
                           input int stall_at, input int stall_len, input bit gaps,
                           input string tag);
        int c0, r0, d0, wc, rdt;
        bit err;
        c0 = cap_tog; r0 = rd_tog; d0 = done_cnt;
        model(cap, rd, thumb, cap_delay >= 0, supply, stall_at, stall_len, err, wc, rdt);
        check({tag, "_ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_capture = cap; req_readout = rd;
        req_ramBlock = ram; req_skipCount = skip; req_thumb = thumb;
        last_drv = cyc;
        tick();
        req_valid = 1'b0;
        last_acc = cyc;
        check({tag, "_args"}, {cmd_ramBlock, cmd_skipCount, cmd_thumb}, {ram, skip, thumb});
        if (cap && cap_delay >= 0) begin
            repeat (cap_delay) tick();
            status_captureDone = ~status_captureDone;
            last_stat = cyc;
        end
        if (rdt != 0) begin
            wait_rd(r0, tag);
            repeat (2) tick();
            supply_words(supply, stall_at, stall_len, gaps);
        end
        wait_done(d0, tag);
        tick();
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_err"}, last_err, err);
        check({tag, "_wc"}, last_wc, wc);
        check({tag, "_cap_toggles"}, cap_tog - c0, cap);
        check({tag, "_rd_toggles"}, rd_tog - r0, rdt);
        repeat (2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, dc, need, supply, stall_at, stall_len, cap_delay;
        bit cap, rd, thumb, held_ok;

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy_done", {busy, done, done_err}, 0);
        check("rst_cmds", {cmd_capture, cmd_readout, cmd_ramBlock, cmd_skipCount, cmd_thumb}, 0);
        check("rst_wc", done_wordCount, 0);
        rst_ = 1'b1;
        repeat (2) tick();

        // Readout only, thumbnail, back-to-back words
        run_req(0, 1, 0, 0, 1, 0, THUMB + PAD, -1, 0, 0, "rd_thumb");
        check("rd_accept_to_toggle", rd_tog_cyc - last_drv, 1);
        check("rd_lastword_to_done", done_cyc - last_word, 1);

        // Capture + readout on RAM block 1, capture completes 50 cycles after issue
        run_req(1, 1, 1, 0, 0, 50, WORDS + PAD, -1, 0, 1, "cap_rd");
        check("cap_accept_to_toggle", cap_tog_cyc - last_drv, 1);
        check("capdone_to_rd_toggle", rd_tog_cyc - last_stat, 1);
        check("cap_rd_args_stable", arg_chg, 0);

        // Capture never completes: timeout T+2 cycles after the accepting edge
        run_req(1, 1, 0, 1, 0, -1, 0, -1, 0, 0, "cap_to");
        check("cap_timeout_latency", done_cyc - last_acc, T + 2);

        // Readout stall shorter than timeout, then one longer than timeout after word 10
        run_req(0, 1, 0, 0, 0, 0, WORDS + PAD, 20, 100, 1, "rd_stall_ok");
        run_req(0, 1, 1, 1, 0, 0, WORDS + PAD, 10, T + 100, 0, "rd_stall_to");

        // Neither phase requested
        run_req(0, 0, 1, 0, 1, 0, 0, -1, 0, 0, "empty");

        // Request held while busy: ignored, then accepted in the cycle after done
        req_valid = 1'b1; req_capture = 1'b1; req_readout = 1'b0;
        req_ramBlock = 1'b1; req_skipCount = 1'b1; req_thumb = 1'b1;
        tick();
        req_capture = 1'b0; req_readout = 1'b1;
        req_ramBlock = 1'b0; req_skipCount = 1'b0; req_thumb = 1'b0;
        r0 = rd_tog; d0 = done_cnt; held_ok = 1'b1;
        repeat (20) begin
            if (req_ready !== 1'b0 || cmd_ramBlock !== 1'b1) held_ok = 1'b0;
            tick();
        end
        check("busy_ignored", {held_ok, rd_tog - r0}, {1'b1, 32'd0});
        status_captureDone = ~status_captureDone;
        wait_done(d0, "busy_cap");
        dc = done_cyc;
        check("busy_cap_wc", {last_err, last_wc}, 0);
        wait_rd(r0, "busy_next");
        req_valid = 1'b0;
        check("accept_after_done", rd_tog_cyc - dc, 2);
        check("next_args", {cmd_ramBlock, cmd_skipCount, cmd_thumb}, 3'b000);
        d0 = done_cnt;
        repeat (2) tick();
        supply_words(WORDS + PAD, -1, 0, 0);
        wait_done(d0, "busy_rd");
        check("busy_rd_result", {last_err, last_wc}, {1'b0, 24'(WORDS + PAD)});
        repeat (3) tick();

        // Randomized requests against the reference model
        for (int k = 0; k < 10; k++) begin
            cap = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            thumb = 1'($urandom_range(0, 1));
            need = thumb ? THUMB + PAD : WORDS + PAD;
            cap_delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(3, 60));
            supply = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, need - 1))
                                                 : need + int'($urandom_range(0, 2));
            stall_at = -1; stall_len = 0;
            if ($urandom_range(0, 3) == 0) begin
                stall_at  = int'($urandom_range(0, need - 1));
                stall_len = ($urandom_range(0, 1) == 0) ? 100 : T + 100;
            end
            run_req(cap, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), thumb,
                    cap_delay, supply, stall_at, stall_len, 1, $sformatf("rnd%0d", k));
        end
        check("rnd_args_stable", arg_chg, 0);

        // Reset during readout counting: immediate abort, no done pulse
        r0 = rd_tog;
        req_valid = 1'b1; req_capture = 1'b0; req_readout = 1'b1;
        req_ramBlock = 1'b1; req_skipCount = 1'b1; req_thumb = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_rd(r0, "rst_mid");
        repeat (2) tick();
        supply_words(5, -1, 0, 0);
        d0 = done_cnt;
        rst_ = 1'b0;
        tick();
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_outs", {busy, done, done_err, cmd_capture, cmd_readout,
                               cmd_ramBlock, cmd_skipCount, cmd_thumb}, 0);
        check("rst_mid_wc", done_wordCount, 0);
        rst_ = 1'b1;
        status_captureDone = 1'b0;
        repeat (20) tick();
        check("rst_mid_no_done", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
